// File: rtl/mem_req_arbiter.sv
// Two-client memory request arbiter: per-client request FIFOs, round-robin issue onto a
// registered mem_req, and routing of memory responses back to the owning client.

package mem_req_arbiter_pkg;
    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int ACCESS_ID_WIDTH = 8;
    localparam int CORE_ID_WIDTH   = 4;

    typedef struct packed {
        logic                       vld;
        logic [CORE_ID_WIDTH-1:0]   core_id;
        logic [ACCESS_ID_WIDTH-1:0] access_id;
        logic [ADDR_WIDTH-1:0]      addr;
        logic [DATA_WIDTH-1:0]      data;
    } request_t;
endpackage

module mem_req_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  request_t push_data,
    input  logic     pop,
    output request_t head,
    output logic     head_vld,
    output logic     full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    request_t        slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    // Payload storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    assign head     = slots[rd_ptr];
    assign head_vld = (count != '0);
    assign full     = (count == DEPTH[PW:0]);
endmodule

module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int CORE_ID        = 0,
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  request_t             icache_req,
    output logic                 icache_grant,
    output request_t             icache_rsp,
    input  request_t             dcache_req,
    output logic                 dcache_grant,
    output request_t             dcache_rsp,
    output request_t             mem_req,
    input  logic                 mem_req_ready,
    input  request_t             mem_rsp,
    output logic [CNT_WIDTH-1:0] icache_outstanding,
    output logic [CNT_WIDTH-1:0] dcache_outstanding,
    output logic [CNT_WIDTH-1:0] drop_count
);
    localparam logic [CORE_ID_WIDTH-1:0] OWN_CORE = CORE_ID[CORE_ID_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX  = '1;

    typedef enum logic {SERVED_ICACHE, SERVED_DCACHE} served_t;

    served_t  last_served;
    request_t i_head;
    request_t d_head;
    logic     i_head_vld;
    logic     d_head_vld;
    logic     i_full;
    logic     d_full;
    logic     can_load;
    logic     load;
    logic     pick_d;
    logic     i_pop;
    logic     d_pop;
    logic     rsp_match;
    logic     rsp_to_icache;

    // Grants are forced low during reset so every output reads 0 while reset is held.
    assign icache_grant = reset && icache_req.vld && !i_full;
    assign dcache_grant = reset && dcache_req.vld && !d_full;

    mem_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_icache_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (icache_grant),
        .push_data (icache_req),
        .pop       (i_pop),
        .head      (i_head),
        .head_vld  (i_head_vld),
        .full      (i_full)
    );

    mem_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_dcache_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dcache_grant),
        .push_data (dcache_req),
        .pop       (d_pop),
        .head      (d_head),
        .head_vld  (d_head_vld),
        .full      (d_full)
    );

    // dcache wins when it is the only head, or when both are ready and icache went last.
    assign can_load = !mem_req.vld || mem_req_ready;
    assign load     = can_load && (i_head_vld || d_head_vld);
    assign pick_d   = d_head_vld && (!i_head_vld || (last_served == SERVED_ICACHE));
    assign i_pop    = load && !pick_d;
    assign d_pop    = load && pick_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req     <= '0;
            last_served <= SERVED_ICACHE;
        end else if (load) begin
            mem_req     <= pick_d ? d_head : i_head;
            mem_req.vld <= 1'b1;
            last_served <= pick_d ? SERVED_DCACHE : SERVED_ICACHE;
        end else if (mem_req_ready) begin
            mem_req <= '0;
        end
    end

    // Access ids 64..127 belong to the instruction cache, everything else to the data path.
    assign rsp_match     = mem_rsp.vld && (mem_rsp.core_id == OWN_CORE);
    assign rsp_to_icache = (mem_rsp.access_id[ACCESS_ID_WIDTH-1:ACCESS_ID_WIDTH-2] == 2'b01);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icache_rsp <= '0;
            dcache_rsp <= '0;
        end else begin
            icache_rsp <= '0;
            dcache_rsp <= '0;
            if (rsp_match && rsp_to_icache) begin
                icache_rsp <= mem_rsp;
            end else if (rsp_match) begin
                dcache_rsp <= mem_rsp;
            end
        end
    end

    function automatic logic [CNT_WIDTH-1:0] next_count(
        input logic [CNT_WIDTH-1:0] cnt,
        input logic                 inc,
        input logic                 dec
    );
        logic [CNT_WIDTH-1:0] result;
        result = cnt;
        case ({inc, dec})
            2'b10:   result = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
            2'b01:   result = (cnt == '0) ? cnt : cnt - CNT_WIDTH'(1);
            default: result = cnt;
        endcase
        return result;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icache_outstanding <= '0;
            dcache_outstanding <= '0;
            drop_count         <= '0;
        end else begin
            icache_outstanding <= next_count(icache_outstanding, i_pop, rsp_match && rsp_to_icache);
            dcache_outstanding <= next_count(dcache_outstanding, d_pop, rsp_match && !rsp_to_icache);
            drop_count         <= next_count(drop_count, mem_rsp.vld && !rsp_match, 1'b0);
        end
    end
endmodule
